// File: rtl/miriscv_lsu.sv
// Load/store unit: turns one core memory request into a req/gnt/rvalid bus
// transaction, aligning store data and extending load data by access size.
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] SIZE_BYTE   = 3'd0;
    localparam logic [2:0] SIZE_HALF   = 3'd1;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [2:0] SIZE_UBYTE  = 3'd4;
    localparam logic [2:0] SIZE_UHALF  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic        misaligned;
    logic        illegal_size;
    logic        error_now;
    logic        accept;
    logic        complete;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Request decode: lane enables, replicated store data and legality.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        illegal_size = 1'b0;
        misaligned   = 1'b0;
        be_next      = 4'b0000;
        wdata_next   = lsu_data_i;
        case (lsu_size_i)
            SIZE_BYTE, SIZE_UBYTE: begin
                be_next    = 4'b0001 << lsu_addr_i[1:0];
                wdata_next = {4{lsu_data_i[7:0]}};
            end
            SIZE_HALF, SIZE_UHALF: begin
                be_next    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_next = {2{lsu_data_i[15:0]}};
                misaligned = lsu_addr_i[0];
            end
            SIZE_WORD: begin
                be_next    = 4'b1111;
                misaligned = |lsu_addr_i[1:0];
            end
            default: illegal_size = 1'b1;
        endcase
    end

    assign error_now = (state == ST_IDLE) & lsu_req_i & (misaligned | illegal_size);
    assign accept    = (state == ST_IDLE) & lsu_req_i & ~(misaligned | illegal_size);
    assign complete  = ((state == ST_REQ) & data_gnt_i & data_rvalid_i)
                     | ((state == ST_WAIT) & data_rvalid_i);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; rvalid in REQ only counts together with gnt.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ: begin
                if (data_gnt_i) begin
                    state_next = data_rvalid_i ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: if (data_rvalid_i) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State-derived outputs; the stall is forced low while reset is held.
    always_comb begin
        data_req_o      = (state == ST_REQ);
        lsu_stall_req_o = rst_n_i & lsu_req_i & (state != ST_DONE) & ~error_now;
    end

    // Load extraction uses the lane and size registered at acceptance.
    assign byte_sel = data_rdata_i[{lane_q, 3'b000} +: 8];
    assign half_sel = data_rdata_i[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = data_rdata_i;
        case (size_q)
            SIZE_BYTE:  load_data = {{24{byte_sel[7]}}, byte_sel};
            SIZE_UBYTE: load_data = {24'd0, byte_sel};
            SIZE_HALF:  load_data = {{16{half_sel[15]}}, half_sel};
            SIZE_UHALF: load_data = {16'd0, half_sel};
            default:    load_data = data_rdata_i;
        endcase
    end

    // Bus request fields, error pulse and load result.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= 32'd0;
            data_wdata_o <= 32'd0;
            size_q       <= 3'd0;
            lane_q       <= 2'd0;
            lsu_data_o   <= 32'd0;
            lsu_err_o    <= 1'b0;
        end else begin
            lsu_err_o <= error_now;
            if (accept) begin
                data_we_o    <= lsu_we_i;
                data_be_o    <= be_next;
                data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                data_wdata_o <= wdata_next;
                size_q       <= lsu_size_i;
                lane_q       <= lsu_addr_i[1:0];
            end
            if (complete && !data_we_o) begin
                lsu_data_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Randomised scoreboard bench for miriscv_lsu: a core driver, a memory
// responder with random gnt/rvalid timing and a monitor comparing against a reference model.
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_stall_req_o;
    logic [31:0] lsu_data_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    miriscv_lsu dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_data_o      (lsu_data_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        int          gd;
        int          rv;
        logic [31:0] rdata;
    } rsp_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_data[$];
    rsp_t        rsp_q[$];
    int          err_pending = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_load   = 32'd0;
    bit          outstanding = 1'b0;
    bit          done_next   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Reference model: byte lane arithmetic on the access, independent of any FSM.
    function automatic void ref_model(input logic we, input logic [2:0] size,
                                      input logic [31:0] addr, input logic [31:0] sdata,
                                      input logic [31:0] rword, input logic [31:0] prev,
                                      output bit err, output logic [3:0] be,
                                      output logic [31:0] wd, output logic [31:0] result);
        int          lane;
        logic [31:0] part;
        lane   = int'(addr % 4);
        err    = 1'b0;
        be     = 4'd0;
        wd     = 32'd0;
        result = prev;
        case (size)
            3'd0, 3'd4: begin
                be   = 4'(1 << lane);
                wd   = (sdata & 32'hFF) * 32'h0101_0101;
                part = (rword >> (8 * lane)) & 32'hFF;
                if (!we) result = (size == 3'd0 && part >= 32'd128) ? part - 32'd256 : part;
            end
            3'd1, 3'd5: begin
                err  = (lane % 2) != 0;
                be   = 4'(3 << lane);
                wd   = (sdata & 32'hFFFF) * 32'h0001_0001;
                part = (rword >> (8 * lane)) & 32'hFFFF;
                if (!we) result = (size == 3'd1 && part >= 32'd32768) ? part - 32'd65536 : part;
            end
            3'd2: begin
                err = lane != 0;
                be  = 4'hF;
                wd  = sdata;
                if (!we) result = rword;
            end
            default: err = 1'b1;
        endcase
        if (err) result = prev;
    endfunction

    // Memory responder: random gnt/rvalid delays per accepted request, noise elsewhere.
    initial begin
        rsp_t r;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'd0;
        forever begin
            @(posedge clk_i);
            #1;
            if (data_req_o && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                for (int i = 0; i < r.gd; i++) begin
                    data_gnt_i    = 1'b0;
                    data_rvalid_i = 1'($urandom_range(0, 1));
                    data_rdata_i  = $urandom;
                    @(posedge clk_i);
                    #1;
                end
                data_gnt_i = 1'b1;
                if (r.rv == 0) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = r.rdata;
                end else begin
                    data_rvalid_i = 1'b0;
                    data_rdata_i  = $urandom;
                    for (int i = 0; i < r.rv; i++) begin
                        @(posedge clk_i);
                        #1;
                        data_gnt_i    = 1'b0;
                        data_rvalid_i = 1'b0;
                        data_rdata_i  = $urandom;
                    end
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = r.rdata;
                end
            end else begin
                data_gnt_i    = 1'($urandom_range(0, 1));
                data_rvalid_i = 1'($urandom_range(0, 1));
                data_rdata_i  = $urandom;
            end
        end
    end

    // Monitor: checks bus requests, error pulses and load results as they appear.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            outstanding = 1'b0;
            done_next   = 1'b0;
        end else begin
            if (done_next) begin
                done_next = 1'b0;
                if (exp_data.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
                else check("lsu_data_o", lsu_data_o, exp_data.pop_front());
            end
            if (data_req_o) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_data_req", 32'd1, 32'd0);
                end else begin
                    check("data_we_o",    32'(data_we_o),  32'(exp_bus[0].we));
                    check("data_be_o",    32'(data_be_o),  32'(exp_bus[0].be));
                    check("data_addr_o",  data_addr_o,     exp_bus[0].addr);
                    check("data_wdata_o", data_wdata_o,    exp_bus[0].wdata);
                    if (data_gnt_i) begin
                        void'(exp_bus.pop_front());
                        if (data_rvalid_i) done_next = 1'b1;
                        else outstanding = 1'b1;
                    end
                end
            end else if (outstanding && data_rvalid_i) begin
                outstanding = 1'b0;
                done_next   = 1'b1;
            end
            if (lsu_err_o) begin
                if (err_pending == 0) check("unexpected_lsu_err", 32'd1, 32'd0);
                else begin
                    err_pending--;
                    check("lsu_err_o", 32'(lsu_err_o), 32'd1);
                end
            end
        end
    end

    task automatic idle_inputs();
        lsu_req_i  = 1'b0;
        lsu_we_i   = 1'($urandom_range(0, 1));
        lsu_size_i = 3'($urandom_range(0, 7));
        lsu_addr_i = $urandom;
        lsu_data_i = $urandom;
    endtask

    // One core access: model it, queue expectations, drive until the stall drops.
    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] sdata, input int gd, input int rv,
                         input logic [31:0] rword);
        bit          err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] result;
        int          stalls;
        int          exp_stalls;
        rsp_t        r;
        bus_t        b;
        ref_model(we, size, addr, sdata, rword, last_load, err, be, wd, result);
        if (err) begin
            err_pending++;
            exp_stalls = 0;
        end else begin
            b.we = we; b.be = be; b.addr = addr & 32'hFFFF_FFFC; b.wdata = wd;
            exp_bus.push_back(b);
            r.gd = gd; r.rv = rv; r.rdata = rword;
            rsp_q.push_back(r);
            exp_data.push_back(result);
            last_load  = result;
            exp_stalls = 2 + gd + rv;
        end
        @(posedge clk_i);
        #1;
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = sdata;
        stalls = 0;
        forever begin
            @(negedge clk_i);
            if (!lsu_stall_req_o) break;
            stalls++;
            if (stalls > 200) begin
                check("stall_timeout", 32'(stalls), 32'(exp_stalls));
                finish_run();
            end
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge clk_i);
        #1;
        idle_inputs();
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
    endtask

    initial begin
        logic [2:0]  size_tab[14] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2,
                                      3'd4, 3'd1, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
        logic [2:0]  sz;
        logic [31:0] a;
        rst_n_i    = 1'b0;
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'd2;
        lsu_addr_i = 32'h0000_0040;
        lsu_data_i = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall",     32'(lsu_stall_req_o), 32'd0);
        check("rst_data_req",  32'(data_req_o),      32'd0);
        check("rst_data_we",   32'(data_we_o),       32'd0);
        check("rst_data_be",   32'(data_be_o),       32'd0);
        check("rst_data_addr", data_addr_o,          32'd0);
        check("rst_wdata",     data_wdata_o,         32'd0);
        check("rst_lsu_data",  lsu_data_o,           32'd0);
        check("rst_lsu_err",   32'(lsu_err_o),       32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        idle_inputs();

        issue(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1, $urandom);
        issue(1'b0, 3'd0, 32'h0000_0103, $urandom,      0, 1, 32'h8012_3456);
        issue(1'b0, 3'd4, 32'h0000_0103, $urandom,      1, 0, 32'h8012_3456);
        issue(1'b1, 3'd1, 32'h0000_0022, 32'h1234_ABCD, 0, 2, $urandom);
        issue(1'b0, 3'd2, 32'h0000_0101, $urandom,      0, 0, $urandom);
        issue(1'b0, 3'd1, 32'h0000_0013, $urandom,      0, 0, $urandom);
        issue(1'b0, 3'd3, 32'h0000_0010, $urandom,      0, 0, $urandom);
        issue(1'b1, 3'd6, 32'h0000_0010, $urandom,      0, 0, $urandom);
        issue(1'b0, 3'd7, 32'h0000_0010, $urandom,      0, 0, $urandom);
        issue(1'b0, 3'd2, 32'h0000_0200, $urandom,      0, 0, 32'hCAFE_F00D);
        issue(1'b0, 3'd5, 32'h0000_0202, $urandom,      1, 1, 32'h9ABC_1234);
        issue(1'b0, 3'd1, 32'h0000_0202, $urandom,      0, 3, 32'h9ABC_1234);

        for (int n = 0; n < 300; n++) begin
            sz = size_tab[$urandom_range(0, 13)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, a, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Reset while the load waits for rvalid; the late response must be ignored.
        begin
            bus_t b;
            rsp_t r;
            b.we = 1'b0; b.be = 4'hF; b.addr = 32'h0000_0300; b.wdata = 32'h5555_AAAA;
            exp_bus.push_back(b);
            r.gd = 0; r.rv = 3; r.rdata = 32'h1357_9BDF;
            rsp_q.push_back(r);
            @(posedge clk_i);
            #1;
            lsu_req_i  = 1'b1;
            lsu_we_i   = 1'b0;
            lsu_size_i = 3'd2;
            lsu_addr_i = 32'h0000_0300;
            lsu_data_i = 32'h5555_AAAA;
            repeat (2) @(posedge clk_i);
            #1;
            rst_n_i = 1'b0;
            @(negedge clk_i);
            check("stall_in_reset", 32'(lsu_stall_req_o), 32'd0);
            @(posedge clk_i);
            #1;
            rst_n_i = 1'b1;
            idle_inputs();
            last_load = 32'd0;
            @(negedge clk_i);
            check("post_rst_data_req", 32'(data_req_o), 32'd0);
            check("post_rst_be",       32'(data_be_o),  32'd0);
            check("post_rst_addr",     data_addr_o,     32'd0);
            check("post_rst_wdata",    data_wdata_o,    32'd0);
            check("post_rst_we",       32'(data_we_o),  32'd0);
            check("post_rst_err",      32'(lsu_err_o),  32'd0);
            check("post_rst_lsu_data", lsu_data_o,      32'd0);
            repeat (6) @(posedge clk_i);
            @(negedge clk_i);
            check("late_rvalid_data",  lsu_data_o,      32'd0);
            check("late_rvalid_req",   32'(data_req_o), 32'd0);
        end

        issue(1'b0, 3'd0, 32'h0000_0401, $urandom, 1, 2, 32'h0000_7F00);

        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("bus_q_drained",  32'(exp_bus.size()),  32'd0);
        check("data_q_drained", 32'(exp_data.size()), 32'd0);
        check("err_drained",    32'(err_pending),     32'd0);
        finish_run();
    end

endmodule
